nms_score_window: RTL
=====================

// Module: nms_score_window
// PURPOSE
//  Parametrised NMS score window for the FAST9 accelerator: collects one reference score and
//  NUM_ADJ neighbour scores via addressed writes, and tracks which slots are loaded.
//  When all slots are loaded, presents the whole window to the NMS datapath through a
//  valid/ready handshake. Successor of the fixed 8-neighbour NMS register bank.
//  Adds: load tracking, backpressure, flush, bad-address flag and a window counter.
// PARAMETERS
//  SCORE_W  8   width of one score
//  NUM_ADJ  8   neighbour slot count (1..15)
//  ADDR_W   4   write address width; must satisfy 2**ADDR_W > NUM_ADJ
// PORTS
//  clock      in   1                  clock
//  nReset     in   1                  reset, synchronous, active-low
//  wr_en      in   1                  write strobe
//  wr_addr    in   ADDR_W             0 = reference slot; 1..NUM_ADJ = neighbour slot
//  wr_data    in   SCORE_W            score to store
//  wr_ready   out  1                  window accepting writes
//  flush      in   1                  discard the partial or held window
//  addr_err   out  1                  one-cycle pulse: bad address was written
//  out_valid  out  1                  complete window presented
//  out_ready  in   1                  consumer accepts the window
//  ref_score  out  SCORE_W            reference score
//  adj_score  out  NUM_ADJ*SCORE_W    neighbours; slot 1 in the MSBs, slot NUM_ADJ in the LSBs
//  win_cnt    out  16                 windows transferred, wraps 0xFFFF->0
//  is_max     out  1                  only with NMS_WIN_MAX_FLAG_EN
// BEHAVIOUR
//  - Reset (nReset=0 at a clock edge): state=LOAD, all score regs=0, load mask=0,
//    out_valid=0, addr_err=0, win_cnt=0. wr_ready=1 after reset.
//  - wr_ready = (state==LOAD), combinational.
//  - out_valid = (state==HOLD), registered.
//  - LOAD state, write accepted when wr_en=1:
//      - addr 0..NUM_ADJ: slot <= wr_data; its mask bit is set.
//      - Rewriting an already-loaded slot overwrites the value; mask unchanged.
//      - addr > NUM_ADJ: no store; addr_err=1 on the next cycle, for one cycle.
//  - LOAD->HOLD: on the edge where the mask becomes all-ones.
//      - out_valid rises one cycle after the last write.
//      - Minimum fill time is NUM_ADJ+1 cycles.
//  - HOLD state:
//      - wr_en is ignored: nothing stored, no addr_err.
//      - Outputs are stable while out_ready=0.
//      - out_valid & out_ready at an edge: transfer. Next state LOAD, mask<=0,
//        win_cnt+1. Score regs keep their values.
//  - ref_score, adj_score and is_max drive 0 while out_valid=0, never X.
//  - out_ready is don't-care while out_valid=0.
//  - flush=1 at an edge: state<=LOAD, mask<=0, out_valid<=0. Score regs keep their values.
//  - Priority: reset > flush > transfer/write.
//      - flush with a transfer: no transfer, win_cnt unchanged.
//      - flush with a write: write dropped, no addr_err.
//  - Reset mid-fill or mid-hold: window lost; all outputs return to reset values.
// CONFIGURATION
//  - NMS_WIN_MAX_FLAG_EN defined:
//      - Port is_max exists.
//      - is_max = out_valid & (ref_score > every neighbour), unsigned strict compare.
//      - Any tie gives 0.
//      - Pure combinational from the held registers; no extra latency.
//  - NMS_WIN_MAX_FLAG_EN undefined: is_max port and comparator logic are absent.
//    All other behaviour is identical.
// TESTING (defaults: SCORE_W=8, NUM_ADJ=8)
//  - Fill: write addr 0..8 with data 0x50,0x01..0x08 on consecutive cycles, out_ready=0
//    -> out_valid=1 the cycle after addr 8.
//    -> ref_score=0x50, adj_score=0x0102030405060708, wr_ready=0.
//    -> With the macro: is_max=1.
//  - Backpressure: hold out_ready=0 for 5 cycles, then 1 for 1 cycle
//    -> outputs stable, then one transfer, win_cnt=1, wr_ready=1, out_valid=0.
//    -> Writes during HOLD change nothing.
//  - Overwrite and bad address: write addr 3 twice (0x10 then 0x7F), then addr 12
//    -> slot 3=0x7F; addr_err pulses one cycle; window still not complete.
//  - Tie: ref=0x40, slot 5=0x40, other slots 0x00 -> is_max=0 with the macro.
//  - flush with out_ready in HOLD -> out_valid=0, win_cnt unchanged.
//    -> A full 9-write refill is required before out_valid rises again.
//  - Reset mid-fill after 4 writes -> reset values on all outputs.
//    -> 8 further writes do not raise out_valid; 9 writes do.
//    -> win_cnt wraps 0xFFFF->0x0000 (forced via preload or long run).

Source files
------------

// File: rtl/nms_score_window.sv
`default_nettype none
// ============================================================================
// Module  : nms_score_window
// Brief   : Addressed-write score window (reference + NUM_ADJ neighbours) with
//           load tracking, valid/ready hand-off, flush and bad-address pulse.
//           Optional macro NMS_WIN_MAX_FLAG_EN adds the is_max comparator.
// Revision: 1.0  initial release
// ============================================================================
module nms_score_window #(
    parameter int SCORE_W = 8,
    parameter int NUM_ADJ = 8,
    parameter int ADDR_W  = 4
) (
    input  logic                       clock,
    input  logic                       nReset,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [SCORE_W-1:0]         wr_data,
    output logic                       wr_ready,
    input  logic                       flush,
    output logic                       addr_err,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SCORE_W-1:0]         ref_score,
    output logic [NUM_ADJ*SCORE_W-1:0] adj_score,
    output logic [15:0]                win_cnt
`ifdef NMS_WIN_MAX_FLAG_EN
    ,
    output logic                       is_max
`endif
);

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [SCORE_W-1:0] score_q [0:NUM_ADJ];
    logic [SCORE_W-1:0] score_d [0:NUM_ADJ];
    logic [NUM_ADJ:0]   mask_q, mask_d;
    logic               addr_err_q, addr_err_d;
    logic [15:0]        win_cnt_q, win_cnt_d;

    always_comb begin
        state_d    = state_q;
        score_d    = score_q;
        mask_d     = mask_q;
        addr_err_d = 1'b0;
        win_cnt_d  = win_cnt_q;
        if (flush) begin
            // Flush outranks both a pending write and a pending transfer.
            state_d = ST_LOAD;
            mask_d  = '0;
        end else if (state_q == ST_LOAD) begin
            if (wr_en) begin
                if (wr_addr > ADDR_W'(NUM_ADJ)) begin
                    addr_err_d = 1'b1;
                end else begin
                    for (int i = 0; i <= NUM_ADJ; i++) begin
                        if (wr_addr == ADDR_W'(i)) begin
                            score_d[i] = wr_data;
                            mask_d[i]  = 1'b1;
                        end
                    end
                end
            end
            if (&mask_d) begin
                state_d = ST_HOLD;
            end
        end else if (out_ready) begin
            state_d   = ST_LOAD;
            mask_d    = '0;
            win_cnt_d = win_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!nReset) begin
            state_q    <= ST_LOAD;
            score_q    <= '{default: '0};
            mask_q     <= '0;
            addr_err_q <= 1'b0;
            win_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            score_q    <= score_d;
            mask_q     <= mask_d;
            addr_err_q <= addr_err_d;
            win_cnt_q  <= win_cnt_d;
        end
    end

    assign wr_ready  = (state_q == ST_LOAD);
    assign out_valid = (state_q == ST_HOLD);
    assign addr_err  = addr_err_q;
    assign win_cnt   = win_cnt_q;
    assign ref_score = out_valid ? score_q[0] : '0;

    // Slot 1 lands in the most significant lane of adj_score.
    for (genvar g = 1; g <= NUM_ADJ; g++) begin : g_adj
        assign adj_score[(NUM_ADJ-g)*SCORE_W +: SCORE_W] = out_valid ? score_q[g] : '0;
    end

`ifdef NMS_WIN_MAX_FLAG_EN
    logic ref_gt_all;

    always_comb begin
        ref_gt_all = 1'b1;
        for (int i = 1; i <= NUM_ADJ; i++) begin
            if (score_q[0] <= score_q[i]) begin
                ref_gt_all = 1'b0;
            end
        end
    end

    assign is_max = out_valid & ref_gt_all;
`endif

endmodule
`default_nettype wire
